// File: rtl/mod_leds_pwm.sv
// mod_leds_pwm: memory-mapped LED controller with per-channel PWM brightness and legacy on/off register.
// Optional blink gating (BLINK register, frame counter, phase) is built when LEDS_PWM_BLINK_EN is defined.
module mod_leds_pwm #(
    parameter int N_LEDS   = 8,
    parameter int PWM_BITS = 8,
    parameter int PRESC_W  = 16,
    parameter int BLINK_FR = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ie,
    input  logic              de,
    input  logic [31:0]       iaddr,
    input  logic [31:0]       daddr,
    input  logic [1:0]        drw,
    input  logic [31:0]       din,
    output logic [31:0]       iout,
    output logic [31:0]       dout,
    output logic [N_LEDS-1:0] leds
);
    localparam logic [PWM_BITS-1:0] MAX = '1;

    logic [5:0]          widx;
    logic                wr_en;
    logic [PWM_BITS-1:0] duty [N_LEDS];
    logic [PRESC_W-1:0]  presc;
    logic [PRESC_W-1:0]  presc_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick;
    logic [N_LEDS-1:0]   blank;
    logic                unused_ok;

    assign widx  = daddr[7:2];
    assign wr_en = de & drw[0];
    assign iout  = '0;

    // Bus writes land on the falling edge so the posedge logic sees them half a cycle later.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the duty array is a small flop bank, not RAM, so it takes the async reset like any register.
            for (int i = 0; i < N_LEDS; i++) duty[i] <= MAX;
            presc <= '0;
        end else if (wr_en) begin
            if (widx == 6'd0) begin
                for (int i = 0; i < N_LEDS; i++) duty[i] <= din[i] ? MAX : '0;
            end
            if (widx == 6'd1) presc <= din[PRESC_W-1:0];
            for (int i = 0; i < N_LEDS; i++) begin
                if (widx == 6'(4 + i)) duty[i] <= din[PWM_BITS-1:0];
            end
        end
    end

    // A >= compare lets a shrunken divisor wrap at once instead of running to 2^PRESC_W.
    assign tick = (presc_cnt >= presc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
        end else begin
            presc_cnt <= tick ? '0 : presc_cnt + PRESC_W'(1);
            if (tick) pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

`ifdef LEDS_PWM_BLINK_EN
    localparam int FR_W = $clog2(BLINK_FR + 1);

    logic [N_LEDS-1:0] mask;
    logic [FR_W-1:0]   frame_cnt;
    logic              phase;

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            mask <= '0;
        end else if (wr_en && widx == 6'd2) begin
            mask <= din[N_LEDS-1:0];
        end
    end

    // Phase flips after BLINK_FR complete PWM frames.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else if (tick && pwm_cnt == MAX) begin
            if (frame_cnt == FR_W'(BLINK_FR - 1)) begin
                frame_cnt <= '0;
                phase     <= ~phase;
            end else begin
                frame_cnt <= frame_cnt + FR_W'(1);
            end
        end
    end

    assign blank = mask & {N_LEDS{phase}};
`else
    assign blank = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            leds <= '1;
        end else begin
            for (int i = 0; i < N_LEDS; i++) begin
                leds[i] <= ((duty[i] == MAX) | (pwm_cnt < duty[i])) & ~blank[i];
            end
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns dout and no latch is inferred.
        dout = '0;
        if (de) begin
            if (widx == 6'd0) dout = 32'(leds);
            if (widx == 6'd1) dout = 32'(presc);
`ifdef LEDS_PWM_BLINK_EN
            if (widx == 6'd2) dout = 32'(mask);
`endif
            for (int i = 0; i < N_LEDS; i++) begin
                if (widx == 6'(4 + i)) dout = 32'(duty[i]);
            end
        end
    end

    // Instruction port, read strobe and the unused address/data bits have no function here.
    assign unused_ok = &{1'b0, ie, iaddr, daddr[31:8], daddr[1:0], drw[1], din, (BLINK_FR > 0)};

endmodule

// File: tb/tb_mod_leds_pwm.sv
// Self-checking bench for mod_leds_pwm: register table, PWM duty counting against an arithmetic model,
// prescaler corner cases, async reset and (with LEDS_PWM_BLINK_EN) blink timing.
module tb_mod_leds_pwm;
    localparam int N    = 8;
    localparam int MAXV = 255;
    localparam int TOUT = 4000;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        ie    = 1'b0;
    logic        de    = 1'b0;
    logic [31:0] iaddr = '0;
    logic [31:0] daddr = '0;
    logic [1:0]  drw   = '0;
    logic [31:0] din   = '0;
    logic [31:0] iout;
    logic [31:0] dout;
    logic [N-1:0] leds;

    int total = 0;
    int bad   = 0;
    int hits [N];

    typedef struct {
        bit          do_wr;
        logic [5:0]  idx;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

`ifdef LEDS_PWM_BLINK_EN
    localparam logic [31:0] BLINK_EXP = 32'h1;
`else
    localparam logic [31:0] BLINK_EXP = 32'h0;
`endif

    mod_leds_pwm #(.N_LEDS(N), .PWM_BITS(8), .PRESC_W(16), .BLINK_FR(2)) dut (
        .clk(clk), .rst(rst), .ie(ie), .de(de), .iaddr(iaddr), .daddr(daddr),
        .drw(drw), .din(din), .iout(iout), .dout(dout), .leds(leds)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [5:0] idx, input logic [31:0] data);
        @(posedge clk);
        #1;
        de = 1'b1; drw = 2'b01; daddr = {24'h0, idx, 2'b00}; din = data;
        @(negedge clk);
        #1;
        de = 1'b0; drw = 2'b00; din = '0;
    endtask

    task automatic bus_read(input logic [5:0] idx, output logic [31:0] data);
        de = 1'b1; drw = 2'b10; daddr = {24'h0, idx, 2'b11};
        #1;
        data = dout;
        de = 1'b0; drw = 2'b00;
    endtask

    task automatic measure(input int clocks);
        for (int i = 0; i < N; i++) hits[i] = 0;
        repeat (clocks) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) hits[i] += int'(leds[i]);
        end
    endtask

    task automatic wait_led0(input logic lvl, input string name);
        int n;
        n = 0;
        while (leds[0] !== lvl && n < TOUT) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 32'(n < TOUT), 32'd1);
    endtask

    task automatic run_len(input logic lvl, output int len);
        len = 0;
        while (leds[0] === lvl && len < TOUT) begin
            @(posedge clk);
            #1;
            len++;
        end
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #3 rst = 1'b0;
        #4 rst = 1'b1;
    endtask

    initial begin
        vec_t        tbl [14];
        logic [31:0] rd;
        int          len;

        tbl[0]  = '{1'b1, 6'd0,  32'h0000_00A5, 32'hA5, "legacy_rd"};
        tbl[1]  = '{1'b1, 6'd1,  32'hABCD_0003, 32'h3,  "ctrl_trunc"};
        tbl[2]  = '{1'b1, 6'd4,  32'hFFFF_FF40, 32'h40, "duty0_trunc"};
        tbl[3]  = '{1'b1, 6'd11, 32'h1234_5699, 32'h99, "duty7"};
        tbl[4]  = '{1'b1, 6'd3,  32'hDEAD_BEEF, 32'h0,  "unmapped3"};
        tbl[5]  = '{1'b1, 6'd12, 32'h0000_0077, 32'h0,  "unmapped_past_duty"};
        tbl[6]  = '{1'b0, 6'd4,  32'h0,         32'h40, "duty0_kept"};
        tbl[7]  = '{1'b0, 6'd11, 32'h0,         32'h99, "duty7_kept"};
        tbl[8]  = '{1'b1, 6'd63, 32'h0000_0005, 32'h0,  "unmapped63"};
        tbl[9]  = '{1'b0, 6'd1,  32'h0,         32'h3,  "ctrl_kept"};
        tbl[10] = '{1'b1, 6'd2,  32'h0000_0001, BLINK_EXP, "blink_rd"};
        tbl[11] = '{1'b1, 6'd2,  32'h0000_0000, 32'h0,  "blink_clr"};
        tbl[12] = '{1'b1, 6'd0,  32'h0000_005A, 32'h5A, "legacy_rd2"};
        tbl[13] = '{1'b0, 6'd5,  32'h0,         32'hFF, "legacy_duty1"};

        // Reset state
        #2 rst = 1'b0;
        #1;
        check("rst_leds", 32'(leds), 32'hFF);
        check("rst_iout", iout, 32'h0);
        bus_read(6'd1, rd); check("rst_ctrl", rd, 32'h0);
        bus_read(6'd4, rd); check("rst_duty0", rd, 32'hFF);
        #16 rst = 1'b1;

        // Legacy on/off: leds follow at the next posedge
        bus_write(6'd0, 32'h0000_00A5);
        @(posedge clk); #1;
        check("legacy_leds", 32'(leds), 32'hA5);

        for (int k = 0; k < 14; k++) begin
            if (tbl[k].do_wr) bus_write(tbl[k].idx, tbl[k].wdata);
            @(posedge clk); #1;
            bus_read(tbl[k].idx, rd);
            check(tbl[k].name, rd, tbl[k].exp);
        end

        // de=0: reads give 0 and writes are ignored
        de = 1'b0; drw = 2'b11; daddr = 32'h10; din = 32'h33;
        @(negedge clk); #1;
        check("de0_dout", dout, 32'h0);
        drw = 2'b00; din = '0;
        bus_read(6'd4, rd); check("de0_nowrite", rd, 32'h0);

        // PWM duty counting over one frame, fixed cases
        begin
            int p_tab [4] = '{0, 0, 0, 3};
            int d_tab [4] = '{64, 0, 255, 64};
            for (int k = 0; k < 4; k++) begin
                bus_write(6'd1, 32'(p_tab[k]));
                bus_write(6'd4, 32'(d_tab[k]));
                repeat (2) @(posedge clk);
                measure(256 * (p_tab[k] + 1));
                check($sformatf("pwm_p%0d_d%0d", p_tab[k], d_tab[k]), 32'(hits[0]),
                      32'((d_tab[k] == MAXV) ? 256 * (p_tab[k] + 1) : d_tab[k] * (p_tab[k] + 1)));
            end
        end

        // Randomized duties and prescaler against the on-time arithmetic model
        for (int r = 0; r < 6; r++) begin
            int p;
            int d [N];
            p = int'($urandom_range(0, 2));
            bus_write(6'd1, 32'(p));
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 5))
                    0: d[i] = 0;
                    1: d[i] = MAXV;
                    default: d[i] = int'($urandom_range(0, 255));
                endcase
                bus_write(6'(4 + i), {$urandom_range(0, 32'hFFFF), 8'h00, 8'(d[i])});
            end
            repeat (2) @(posedge clk);
            measure(256 * (p + 1));
            for (int i = 0; i < N; i++) begin
                check($sformatf("rnd%0d_ch%0d_d%0d_p%0d", r, i, d[i], p), 32'(hits[i]),
                      32'((d[i] == MAXV) ? 256 * (p + 1) : d[i] * (p + 1)));
            end
        end

        // Prescaler: shrinking the divisor mid-count ticks at the next clock
        reset_pulse();
        bus_write(6'd1, 32'd100);
        bus_write(6'd4, 32'd8);
        wait_led0(1'b0, "presc_reach8");
        bus_write(6'd4, 32'd9);
        bus_write(6'd1, 32'd0);
        @(posedge clk); #1;
        check("presc_hold_cnt8", 32'(leds[0]), 32'd1);
        @(posedge clk); #1;
        check("presc_tick_next", 32'(leds[0]), 32'd0);

`ifdef LEDS_PWM_BLINK_EN
        // Blink with BLINK_FR=2: 2 frames on, 2 frames off
        bus_write(6'd0, 32'hFF);
        bus_write(6'd2, 32'h1);
        wait_led0(1'b0, "blink_find_off");
        wait_led0(1'b1, "blink_find_on");
        run_len(1'b1, len); check("blink_on_len", 32'(len), 32'd512);
        run_len(1'b0, len); check("blink_off_len", 32'(len), 32'd512);
        wait_led0(1'b0, "blink_find_off2");
        bus_write(6'd2, 32'h0);
        @(posedge clk); #1;
        check("blink_mask_clr", 32'(leds[0]), 32'd1);
`endif

        // Reset mid-frame forces leds on without a clock edge
        bus_write(6'd1, 32'd5);
        bus_write(6'd0, 32'h00);
        @(posedge clk); #1;
        check("pre_rst_leds", 32'(leds), 32'h00);
        #2 rst = 1'b0;
        #1;
        check("async_rst_leds", 32'(leds), 32'hFF);
        bus_read(6'd1, rd); check("async_rst_ctrl", rd, 32'h0);
        bus_read(6'd4, rd); check("async_rst_duty0", rd, 32'hFF);
        #10 rst = 1'b1;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
